// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states and requester ids.
package mem_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// Two-requester round-robin pick: on a tie the requester that was not served last wins.
module rr_arbiter2
    import mem_access_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_i,
    output owner_e     gnt_id_o,
    output logic       gnt_valid_o
);

    // Grant selection from the request vector and the last owner.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = OWN_IF;
        unique case (req_i)
            2'b01:   gnt_id_o = OWN_IF;
            2'b10:   gnt_id_o = OWN_D;
            2'b11:   gnt_id_o = (last_i == OWN_IF) ? OWN_D : OWN_IF;
            default: gnt_id_o = OWN_IF;
        endcase
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Serialises fetch and data accesses onto the single-ported unified memory.
// Each access takes three cycles (IDLE -> SERVE -> DONE); read data is registered per requester.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    owner_e gnt_id;
    logic   gnt_valid;

    rr_arbiter2 u_rr (
        .req_i       ({d_req, if_req}),
        .last_i      (last_q),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid)
    );

    // State, request latch, read-data and done registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            last_q     <= OWN_D;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state logic and memory-side drive.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        memread    = 1'b0;
        memwrite   = 1'b0;
        Address    = '0;
        WriteData  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_id;
                    last_d  = gnt_id;
                    if (gnt_id == OWN_IF) begin
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end else begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                // rst is synchronous, so the bus is gated directly to keep a
                // write from landing during the reset cycle itself.
                if (!rst) begin
                    Address   = addr_q;
                    memread   = ~we_q;
                    memwrite  = we_q;
                    WriteData = wdata_q;
                end
                if (!we_q) begin
                    if (owner_q == OWN_IF) if_rdata_d = ReadData;
                    else                   d_rdata_d  = ReadData;
                end
                if (owner_q == OWN_IF) if_done_d = 1'b1;
                else                   d_done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign if_done  = if_done_q;
    assign d_done   = d_done_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter with a behavioural 32x8 memory.
module tb_mem_access_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       if_req = 1'b0;
    logic [4:0] if_addr = '0;
    logic       if_done;
    logic [7:0] if_rdata;
    logic       d_req = 1'b0;
    logic       d_we = 1'b0;
    logic [4:0] d_addr = '0;
    logic [7:0] d_wdata = '0;
    logic       d_done;
    logic [7:0] d_rdata;
    logic       memread;
    logic       memwrite;
    logic [4:0] Address;
    logic [7:0] WriteData;
    logic [7:0] ReadData;

    logic [7:0] mem [32];
    logic       preload = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        bit         own_d;
        logic [7:0] data;
        int         cy;
    } exp_t;
    exp_t sb[$];

    mem_access_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .memread   (memread),
        .memwrite  (memwrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(int i);
        case (i)
            1:       return 8'h11;
            3:       return 8'hA5;
            5:       return 8'h5A;
            9:       return 8'h55;
            default: return 8'(i) ^ 8'hC0;
        endcase
    endfunction

    // Behavioural memory: combinational read, posedge write, preloaded during first reset.
    always @(posedge clk) begin
        if (rst && preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        end else if (memwrite) begin
            mem[Address] <= WriteData;
        end
    end
    assign ReadData = (memread && !rst) ? mem[Address] : 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_done(input bit own_d, input logic [7:0] data, input int cy);
        exp_t e;
        e.own_d = own_d;
        e.data  = data;
        e.cy    = cy;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (if_done || d_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd1, 32'd0);
        tick(1);
    endtask

    // Monitor: every done pulse must match the next expected access.
    always @(negedge clk) begin
        if (if_done || d_done) begin
            exp_t e;
            chk("both_done", 32'(if_done && d_done), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_owner", 32'(d_done), 32'(e.own_d));
                chk("done_cycle", 32'(cyc), 32'(e.cy));
                chk(e.own_d ? "d_rdata" : "if_rdata",
                    32'(e.own_d ? d_rdata : if_rdata), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        // 1. Reset with both requests asserted.
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1;
        repeat (2) begin
            tick(1);
            @(negedge clk);
            chk("rst_memread", 32'(memread), 32'd0);
            chk("rst_memwrite", 32'(memwrite), 32'd0);
            chk("rst_if_rdata", 32'(if_rdata), 32'd0);
            chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        end
        tick(1);
        preload = 1'b0; rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        tick(1);

        // 2. Single fetch of mem[3].
        expect_done(1'b0, 8'hA5, cyc + 2);
        if_addr = 5'd3; if_req = 1'b1;
        wait_done();
        if_req = 1'b0;
        tick(1);

        // 3. Data write then read back; write leaves d_rdata at 0.
        expect_done(1'b1, 8'h00, cyc + 2);
        d_we = 1'b1; d_addr = 5'd7; d_wdata = 8'h3C; d_req = 1'b1;
        wait_done();
        d_req = 1'b0; d_we = 1'b0;
        tick(1);
        chk("mem7_written", 32'(mem[7]), 32'h3C);
        expect_done(1'b1, 8'h3C, cyc + 2);
        d_addr = 5'd7; d_req = 1'b1;
        wait_done();
        d_req = 1'b0;
        tick(1);

        // 4. Contention after reset: IF, D, IF, D every 3 cycles.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst2_d_rdata", 32'(d_rdata), 32'd0);
        c = cyc;
        if_addr = 5'd3; d_addr = 5'd5; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        expect_done(1'b0, 8'hA5, c + 2);
        expect_done(1'b1, 8'h5A, c + 5);
        expect_done(1'b0, 8'hA5, c + 8);
        expect_done(1'b1, 8'h5A, c + 11);
        tick(12);
        if_req = 1'b0; d_req = 1'b0;
        tick(2);

        // 5. Held fetch request: second fetch (new address) completes 3 cycles later.
        c = cyc;
        if_addr = 5'd3; if_req = 1'b1;
        expect_done(1'b0, 8'hA5, c + 2);
        expect_done(1'b0, 8'h11, c + 5);
        tick(1);
        if_addr = 5'd1;
        tick(3);
        if_req = 1'b0;
        tick(3);

        // 6. Reset during SERVE of a write: no write, no done, back to IDLE.
        d_we = 1'b1; d_addr = 5'd9; d_wdata = 8'hFF; d_req = 1'b1;
        tick(1);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("rst_serve_memwrite", 32'(memwrite), 32'd0);
        tick(1);
        rst = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("post_rst_memwrite", 32'(memwrite), 32'd0);
        tick(4);
        chk("mem9_unchanged", 32'(mem[9]), 32'h55);
        expect_done(1'b0, 8'h55, cyc + 2);
        if_addr = 5'd9; if_req = 1'b1;
        wait_done();
        if_req = 1'b0;
        tick(3);

        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
